fpga_rst_seq: RTL

Board-level reset sequencer for the Nexys PULPissimo FPGA target. It sits between the raw board reset button, clock-generator lock and software reset request on one side, and the SoC reset inputs on the other. It synchronizes and debounces the button and synchronizes PLL lock. It then releases peripheral reset and SoC reset in a fixed, staggered order, and reasserts both on any reset cause.

---
 rtl/fpga_rst_seq_pkg.sv | 20 ++
 rtl/rst_debounce.sv | 45 ++++
 rtl/fpga_rst_seq.sv | 132 +++++++++++++
 3 files changed

// File: rtl/fpga_rst_seq_pkg.sv
// Shared types for the board reset sequencer:
// sequencer states and recorded reset causes.
package fpga_rst_seq_pkg;

  typedef enum logic [2:0] {
    ASSERT,
    WAIT_LOCK,
    HOLD,
    STAGGER,
    RUN
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_POR = 2'b00,
    CAUSE_BTN = 2'b01,
    CAUSE_PLL = 2'b10,
    CAUSE_SW  = 2'b11
  } cause_e;

endpackage

// File: rtl/rst_debounce.sv
// Two-flop synchronizer plus debouncer for the board button.
// The stable level resets to 0 so a release must be proven.
module rst_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic raw,
  output logic level
);

  localparam int unsigned W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [W-1:0] LAST = W'(DEBOUNCE_CYCLES - 1);

  logic         s1;
  logic         s2;
  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
    end else if (clr) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      cnt <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      // any return to the held level restarts the stability window
      if (s2 == level) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        level <= s2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + W'(1);
      end
    end
  end

endmodule

// File: rtl/fpga_rst_seq.sv
// Board reset sequencer: conditions button and PLL lock,
// then releases peripheral and SoC resets in staggered order.
module fpga_rst_seq
  import fpga_rst_seq_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned HOLD_CYCLES     = 64,
  parameter int unsigned STAGGER_CYCLES  = 8,
  parameter int unsigned CNT_WIDTH       = 16
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       btn_rst_ni,
  input  logic       pll_locked_i,
  input  logic       sw_rst_req_i,
  output logic       periph_rst_no,
  output logic       soc_rst_no,
  output logic       busy_o,
  output logic [1:0] rst_cause_o
);

  localparam logic [CNT_WIDTH-1:0] HOLD_LAST =
    CNT_WIDTH'(HOLD_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] STAG_LAST =
    CNT_WIDTH'(STAGGER_CYCLES - 1);

  state_e               state;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 lock_s1;
  logic                 lock_s;
  logic                 btn_db;
  logic                 clr;
  logic                 abort;
  cause_e               abort_cause;

  // conditioning logic is held clear while in ASSERT
  assign clr = (state == ASSERT);

  rst_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .clk  (clk_i),
    .rst_n(rst_ni),
    .clr  (clr),
    .raw  (btn_rst_ni),
    .level(btn_db)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_s1 <= 1'b0;
      lock_s  <= 1'b0;
    end else if (clr) begin
      lock_s1 <= 1'b0;
      lock_s  <= 1'b0;
    end else begin
      lock_s1 <= pll_locked_i;
      lock_s  <= lock_s1;
    end
  end

  always_comb begin
    abort       = !lock_s || !btn_db;
    abort_cause = !lock_s ? CAUSE_PLL : CAUSE_BTN;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state         <= ASSERT;
      cnt           <= '0;
      periph_rst_no <= 1'b0;
      soc_rst_no    <= 1'b0;
      busy_o        <= 1'b1;
      rst_cause_o   <= CAUSE_POR;
    end else begin
      unique case (state)
        ASSERT: begin
          state <= WAIT_LOCK;
        end
        WAIT_LOCK: begin
          if (lock_s && btn_db) begin
            cnt   <= '0;
            state <= HOLD;
          end
        end
        HOLD: begin
          if (abort) begin
            periph_rst_no <= 1'b0;
            soc_rst_no    <= 1'b0;
            busy_o        <= 1'b1;
            rst_cause_o   <= abort_cause;
            state         <= WAIT_LOCK;
          end else if (cnt == HOLD_LAST) begin
            periph_rst_no <= 1'b1;
            cnt           <= '0;
            state         <= STAGGER;
          end else begin
            cnt <= cnt + CNT_WIDTH'(1);
          end
        end
        STAGGER: begin
          if (abort) begin
            periph_rst_no <= 1'b0;
            soc_rst_no    <= 1'b0;
            busy_o        <= 1'b1;
            rst_cause_o   <= abort_cause;
            state         <= WAIT_LOCK;
          end else if (cnt == STAG_LAST) begin
            soc_rst_no <= 1'b1;
            busy_o     <= 1'b0;
            state      <= RUN;
          end else begin
            cnt <= cnt + CNT_WIDTH'(1);
          end
        end
        RUN: begin
          if (abort || sw_rst_req_i) begin
            periph_rst_no <= 1'b0;
            soc_rst_no    <= 1'b0;
            busy_o        <= 1'b1;
            rst_cause_o   <= abort ? abort_cause : CAUSE_SW;
            state         <= WAIT_LOCK;
          end
        end
        default: begin
          state <= ASSERT;
        end
      endcase
    end
  end

endmodule
